lfsr_stream: RTL and testbench

//  Parametrised Galois LFSR pseudo-random source, next generation of the fixed 16-bit LFSR.

---
 rtl/lfsr_pkg.sv | 19 +
 rtl/lfsr_stream_core.sv | 48 ++++
 rtl/lfsr_stream.sv | 75 +++++++
 tb/tb_lfsr_stream.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR helpers: Galois step function and common polynomial/seed constants.
package lfsr_pkg;

  localparam int unsigned STEP_W = 32;

  localparam logic [7:0]  POLY8  = 8'hB8;
  localparam logic [15:0] POLY16 = 16'hB400;
  localparam logic [31:0] POLY32 = 32'hA3000000;
  localparam logic [15:0] SEED16 = 16'hACE1;

  // One Galois step. Narrower LFSRs pass zero-extended state and poly; the upper bits stay zero.
  function automatic logic [STEP_W-1:0] lfsr_galois_step(input logic [STEP_W-1:0] state,
                                                         input logic [STEP_W-1:0] poly);
    logic [STEP_W-1:0] shifted;
    shifted = state >> 1;
    return state[0] ? (shifted ^ poly) : shifted;
  endfunction

endpackage

// File: rtl/lfsr_stream_core.sv
// LFSR state register with seed load, zero-seed lockup guard and STEPS-unrolled advance.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned     WIDTH        = 16,
  parameter logic [WIDTH-1:0] POLY        = POLY16,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = SEED16,
  parameter int unsigned     STEPS        = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state,
  output logic             lockup
);

  logic [WIDTH-1:0] next_state_c;
  logic             seed_zero_c;

  // Apply the Galois step STEPS times per delivered sample.
  always_comb begin
    next_state_c = state;
    for (int unsigned i = 0; i < STEPS; i++) begin
      next_state_c = WIDTH'(lfsr_galois_step(STEP_W'(next_state_c), STEP_W'(POLY)));
    end
  end

  assign seed_zero_c = (seed == '0);

  // A zero seed would lock the register; substitute the default and flag it for one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= SEED_DEFAULT;
      lockup <= 1'b0;
    end else begin
      lockup <= 1'b0;
      if (seed_load) begin
        state  <= seed_zero_c ? SEED_DEFAULT : seed;
        lockup <= seed_zero_c;
      end else if (advance) begin
        state <= next_state_c;
      end
    end
  end

endmodule

// File: rtl/lfsr_stream.sv
// Parametrised Galois LFSR source with seed load, enable and a valid/ready output stream.
// Optional accepted-sample counter when LFSR_STREAM_COUNT_EN is defined.
module lfsr_stream
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH        = 16,
  parameter logic [WIDTH-1:0] POLY         = POLY16,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = SEED16,
  parameter int unsigned      STEPS        = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
`ifdef LFSR_STREAM_COUNT_EN
  output logic [31:0]      sample_count,
`endif
  output logic             lockup
);

  logic [WIDTH-1:0] state;
  logic             slot_free_c;
  logic             advance_c;

  // The output slot can take a new sample when empty or being drained this cycle.
  assign slot_free_c = !m_valid || m_ready;
  assign advance_c   = enable && slot_free_c && !seed_load;

  lfsr_core #(
    .WIDTH        (WIDTH),
    .POLY         (POLY),
    .SEED_DEFAULT (SEED_DEFAULT),
    .STEPS        (STEPS)
  ) u_core (
    .clock     (clock),
    .reset     (reset),
    .advance   (advance_c),
    .seed_load (seed_load),
    .seed      (seed),
    .state     (state),
    .lockup    (lockup)
  );

  // Output register; a seed load flushes any pending sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_data  <= '0;
      m_valid <= 1'b0;
    end else if (seed_load) begin
      m_valid <= 1'b0;
    end else if (advance_c) begin
      m_data  <= state;
      m_valid <= 1'b1;
    end else if (!enable && m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef LFSR_STREAM_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample_count <= '0;
    end else if (seed_load) begin
      sample_count <= '0;
    end else if (m_valid && m_ready) begin
      sample_count <= sample_count + 32'(1);
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_stream.sv
// Self-checking bench for lfsr_stream: directed sequence plus randomized traffic against a model.
module tb_lfsr_stream;
  import lfsr_pkg::*;

  logic        clock     = 1'b0;
  logic        reset     = 1'b0;
  logic        enable    = 1'b0;
  logic        seed_load = 1'b0;
  logic        m_ready   = 1'b0;
  logic [15:0] seed      = 16'h0;

  logic [15:0] m_data, m_data2;
  logic        m_valid, m_valid2;
  logic        lockup, lockup2;
`ifdef LFSR_STREAM_COUNT_EN
  logic [31:0] sample_count, sample_count2;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [15:0] ms, md, ms2, md2;
  logic        mv, mlk;
  int unsigned mcnt;
  logic        zero_seen;

  always #5 clock = ~clock;

  lfsr_stream #(.WIDTH(16), .POLY(16'hB400), .SEED_DEFAULT(16'hACE1), .STEPS(1)) u_dut (
    .clock(clock), .reset(reset), .enable(enable), .seed_load(seed_load), .seed(seed),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
`ifdef LFSR_STREAM_COUNT_EN
    .sample_count(sample_count),
`endif
    .lockup(lockup)
  );

  lfsr_stream #(.WIDTH(16), .POLY(16'hB400), .SEED_DEFAULT(16'hACE1), .STEPS(2)) u_dut2 (
    .clock(clock), .reset(reset), .enable(enable), .seed_load(seed_load), .seed(seed),
    .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready),
`ifdef LFSR_STREAM_COUNT_EN
    .sample_count(sample_count2),
`endif
    .lockup(lockup2)
  );

  function automatic logic [15:0] ref_step(input logic [15:0] s, input int n);
    int unsigned v;
    v = 32'(s);
    for (int k = 0; k < n; k++) begin
      if (v % 2 == 1) v = (v / 2) ^ 32'hB400;
      else            v = v / 2;
    end
    return 16'(v);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ms = 16'hACE1; ms2 = 16'hACE1; md = 16'h0; md2 = 16'h0;
    mv = 1'b0; mlk = 1'b0; mcnt = 0;
  endtask

  task automatic model_edge();
    if (seed_load) begin
      mlk  = (seed == 16'h0);
      ms   = (seed == 16'h0) ? 16'hACE1 : seed;
      ms2  = ms;
      mv   = 1'b0;
      mcnt = 0;
    end else begin
      mlk = 1'b0;
      if (mv && m_ready) mcnt++;
      if (enable && (!mv || m_ready)) begin
        md = ms; md2 = ms2;
        ms = ref_step(ms, 1); ms2 = ref_step(ms2, 2);
        mv = 1'b1;
      end else if (!enable && m_ready) begin
        mv = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    check("m_valid", 32'(m_valid), 32'(mv));
    check("m_data", 32'(m_data), 32'(md));
    check("lockup", 32'(lockup), 32'(mlk));
    check("m_valid_s2", 32'(m_valid2), 32'(mv));
    check("m_data_s2", 32'(m_data2), 32'(md2));
`ifdef LFSR_STREAM_COUNT_EN
    check("sample_count", sample_count, mcnt);
`endif
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    // Reset state
    #1 reset = 1'b1;
    #1;
    model_reset();
    check("rst_valid", 32'(m_valid), 32'h0);
    check("rst_data", 32'(m_data), 32'h0);
    check("rst_lockup", 32'(lockup), 32'h0);
    @(posedge clock); #1 reset = 1'b0;

    // Reference sequence, and STEPS=2 skipping every other value
    enable = 1'b1; m_ready = 1'b1;
    tick(); check("seq0", 32'(m_data), 32'hACE1); check("seq0_v", 32'(m_valid), 32'h1);
    check("s2_seq0", 32'(m_data2), 32'hACE1);
    tick(); check("seq1", 32'(m_data), 32'hE270); check("s2_seq1", 32'(m_data2), 32'h7138);

    // Backpressure holds E270
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); check("hold", 32'(m_data), 32'hE270); check("hold_v", 32'(m_valid), 32'h1);
    end
    m_ready = 1'b1;
    tick(); check("seq2", 32'(m_data), 32'h7138);
    tick(); check("seq3", 32'(m_data), 32'h389C);

    // Seed load mid-stream
    seed = 16'h0001; seed_load = 1'b1;
    tick(); check("load_flush", 32'(m_valid), 32'h0);
    seed_load = 1'b0;
    tick(); check("load0", 32'(m_data), 32'h0001);
    tick(); check("load1", 32'(m_data), 32'hB400);
    tick(); check("load2", 32'(m_data), 32'h5A00);

    // Zero seed triggers lockup replacement
    seed = 16'h0000; seed_load = 1'b1;
    tick(); check("lockup_pulse", 32'(lockup), 32'h1);
    seed_load = 1'b0;
    tick(); check("lockup_clear", 32'(lockup), 32'h0); check("lock_seq0", 32'(m_data), 32'hACE1);
    tick(); check("lock_seq1", 32'(m_data), 32'hE270);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      enable    = ($urandom_range(0, 9) < 8);
      m_ready   = ($urandom_range(0, 9) < 7);
      seed_load = ($urandom_range(0, 19) == 0);
      seed      = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      tick();
    end

    // Full period wrap
    seed = 16'hACE1; seed_load = 1'b1; enable = 1'b1; m_ready = 1'b1;
    tick();
    seed_load = 1'b0;
    tick();
    zero_seen = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      tick();
      if (m_data == 16'h0) zero_seen = 1'b1;
    end
    check("wrap_data", 32'(m_data), 32'hACE1);
    check("never_zero", 32'(zero_seen), 32'h0);
`ifdef LFSR_STREAM_COUNT_EN
    check("wrap_count", sample_count, 32'd65535);
`endif

    // Async reset mid-stream under backpressure
    m_ready = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("arst_valid", 32'(m_valid), 32'h0);
    check("arst_data", 32'(m_data), 32'h0);
    check("arst_valid_s2", 32'(m_valid2), 32'h0);
    check("arst_data_s2", 32'(m_data2), 32'h0);
    @(posedge clock); #1 reset = 1'b0;
    m_ready = 1'b1;
    tick(); check("post_rst0", 32'(m_data), 32'hACE1); check("post_rst0_s2", 32'(m_data2), 32'hACE1);
    tick(); check("post_rst1", 32'(m_data), 32'hE270); check("post_rst1_s2", 32'(m_data2), 32'h7138);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
